// File: rtl/ysyx_23060203_lsu_if.sv
// ysyx_23060203_lsu_if: request/completion handshake plus AXI4-Lite master bus for the LSU.
interface ysyx_23060203_lsu_if;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [2:0]  in_rfunc, in_wfunc;
    logic [31:0] in_raddr, in_waddr, in_wdata;
    logic        out_valid, out_err;
    logic [31:0] out_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    modport master (
        input  in_valid, in_ren, in_wen, in_rfunc, in_wfunc, in_raddr, in_waddr, in_wdata,
        output in_ready, out_valid, out_err, out_rdata,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );
    modport slave (
        output in_valid, in_ren, in_wen, in_rfunc, in_wfunc, in_raddr, in_waddr, in_wdata,
        input  in_ready, out_valid, out_err, out_rdata,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_23060203_lsu.sv
// ysyx_23060203_lsu: RV32 load/store unit issuing word-aligned AXI4-Lite transfers.
module ysyx_23060203_lsu (
    input logic clk,
    input logic rst,
    ysyx_23060203_lsu_if.master bus
);
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]  funct_q, funct_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] req_addr, sh, ld;
    logic [2:0]  req_funct;
    logic        legal, mis, bad;
    always_comb begin
        req_addr  = bus.in_ren ? bus.in_raddr : bus.in_waddr;
        req_funct = bus.in_ren ? bus.in_rfunc : bus.in_wfunc;
        legal     = bus.in_ren ? req_funct inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                               : req_funct inside {3'b000, 3'b001, 3'b010};
        mis       = (req_funct[1:0] == 2'b01 && req_addr[0]) || (req_funct[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        bad       = (bus.in_ren == bus.in_wen) || !legal || mis;
        sh        = bus.rdata >> {addr_q[1:0], 3'b000};
        ld        = funct_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                    funct_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                    funct_q == 3'b100 ? {24'b0, sh[7:0]} :
                    funct_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
        state_d   = state_q;
        addr_d    = addr_q;
        funct_d   = funct_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                addr_d    = req_addr;
                funct_d   = req_funct;
                wdata_d   = req_funct == 3'b000 ? {4{bus.in_wdata[7:0]}} :
                            req_funct == 3'b001 ? {2{bus.in_wdata[15:0]}} : bus.in_wdata;
                wstrb_d   = req_funct == 3'b000 ? 4'b0001 << req_addr[1:0] :
                            req_funct == 3'b001 ? 4'b0011 << req_addr[1:0] : 4'b1111;
                rdata_d   = '0;
                err_d     = bad && !(!bus.in_ren && !bus.in_wen);
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = bad ? RESP : bus.in_ren ? AR : AW_W;
            end
            AR:   state_d = bus.arready ? R : AR;
            R: if (bus.rvalid) begin
                err_d   = bus.rresp != 2'b00;
                rdata_d = bus.rresp != 2'b00 ? 32'b0 : ld;
                state_d = RESP;
            end
            AW_W: begin
                aw_done_d = aw_done_q || bus.awready;
                w_done_d  = w_done_q || bus.wready;
                state_d   = aw_done_d && w_done_d ? B : AW_W;
            end
            B: if (bus.bvalid) begin
                err_d   = bus.bresp != 2'b00;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            funct_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct_q   <= funct_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == RESP;
    assign bus.out_err   = err_q;
    assign bus.out_rdata = rdata_q;
    assign bus.araddr    = {addr_q[31:2], 2'b00};
    assign bus.awaddr    = {addr_q[31:2], 2'b00};
    assign bus.arvalid   = state_q == AR;
    assign bus.rready    = state_q == R;
    assign bus.awvalid   = state_q == AW_W && !aw_done_q;
    assign bus.wvalid    = state_q == AW_W && !w_done_q;
    assign bus.bready    = state_q == B;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// tb_ysyx_23060203_lsu: directed load/store vectors against a scripted AXI4-Lite slave.
module tb_ysyx_23060203_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int aw_dly = 0;
    int lat, w_cyc;
    logic saw_ar, er;
    logic [31:0] ar_a, aw_a, w_d, rd;
    logic [3:0] w_s;
    ysyx_23060203_lsu_if bus();
    ysyx_23060203_lsu dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run(input logic ren, input logic wen, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_ren = ren;
        bus.in_wen = wen;
        bus.in_rfunc = ren ? f : 3'b111;
        bus.in_wfunc = ren ? 3'b111 : f;
        bus.in_raddr = ren ? a : 32'hDEAD_0000;
        bus.in_waddr = ren ? 32'hDEAD_0000 : a;
        bus.in_wdata = d;
        saw_ar = 1'b0; w_cyc = 0; ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            bus.awready = lat > aw_dly;
            if (bus.arvalid) begin saw_ar = 1'b1; ar_a = bus.araddr; end
            if (bus.awvalid) aw_a = bus.awaddr;
            if (bus.wvalid) begin w_cyc++; w_d = bus.wdata; w_s = bus.wstrb; end
            if (bus.out_valid) break;
            tick();
            lat++;
        end
        rd = bus.out_rdata;
        er = bus.out_err;
        tick();
        chk("pulse_one_cycle", {31'b0, bus.out_valid}, 32'd0);
        chk("ready_after", {31'b0, bus.in_ready}, 32'd1);
    endtask
    initial begin
        bus.in_valid = 0; bus.in_ren = 0; bus.in_wen = 0; bus.in_rfunc = 0; bus.in_wfunc = 0;
        bus.in_raddr = 0; bus.in_waddr = 0; bus.in_wdata = 0;
        bus.arready = 1; bus.rvalid = 1; bus.rdata = 0; bus.rresp = 0;
        bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 0;
        tick();
        chk("rst_valids", {26'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.out_valid}, 32'd0);
        chk("rst_out", {bus.out_rdata[30:0], bus.out_err}, 32'd0);
        chk("rst_addr", bus.araddr | bus.awaddr | bus.wdata | {28'b0, bus.wstrb}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.rdata = 32'h80FF_1234;
        run(1, 0, 3'b000, 32'h8000_0003, 0);
        chk("lb_araddr", ar_a, 32'h8000_0000);
        chk("lb_data", rd, 32'hFFFF_FF80);
        chk("lb_err", {31'b0, er}, 32'd0);
        chk("lb_lat", lat, 3);
        bus.rdata = 32'hBEEF_0000;
        run(1, 0, 3'b101, 32'h8000_0002, 0);
        chk("lhu_data", rd, 32'h0000_BEEF);
        run(1, 0, 3'b001, 32'h8000_0002, 0);
        chk("lh_data", rd, 32'hFFFF_BEEF);
        bus.rdata = 32'h0000_F700;
        run(1, 0, 3'b100, 32'h8000_0001, 0);
        chk("lbu_data", rd, 32'h0000_00F7);
        bus.rdata = 32'hCAFE_F00D;
        run(1, 0, 3'b010, 32'h8000_0004, 0);
        chk("lw_data", rd, 32'hCAFE_F00D);
        chk("lw_araddr", ar_a, 32'h8000_0004);
        aw_dly = 2;
        run(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
        aw_dly = 0;
        chk("sh_awaddr", aw_a, 32'h8000_0000);
        chk("sh_wdata", w_d, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'b0, w_s}, 32'hC);
        chk("sh_wcyc", w_cyc, 1);
        chk("sh_lat", lat, 5);
        chk("sh_out", {rd[30:0], er}, 32'd0);
        run(0, 1, 3'b000, 32'h8000_0011, 32'h0000_00A5);
        chk("sb_wdata", w_d, 32'hA5A5_A5A5);
        chk("sb_wstrb", {28'b0, w_s}, 32'h2);
        chk("sb_lat", lat, 3);
        run(0, 1, 3'b010, 32'h8000_0008, 32'h0BAD_BEEF);
        chk("sw_wdata", w_d, 32'h0BAD_BEEF);
        chk("sw_wstrb", {28'b0, w_s}, 32'hF);
        run(1, 0, 3'b010, 32'h8000_0001, 0);
        chk("mis_noar", {31'b0, saw_ar}, 32'd0);
        chk("mis_lat", lat, 1);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_data", rd, 32'd0);
        run(1, 0, 3'b011, 32'h8000_0000, 0);
        chk("ill_noar", {31'b0, saw_ar}, 32'd0);
        chk("ill_out", {lat[30:0], er}, 32'd3);
        run(0, 1, 3'b011, 32'h8000_0000, 0);
        chk("ills_out", {lat[30:0], er}, 32'd3);
        run(0, 1, 3'b001, 32'h8000_0003, 0);
        chk("missh_out", {lat[30:0], er}, 32'd3);
        run(1, 1, 3'b010, 32'h8000_0000, 0);
        chk("both_out", {lat[30:0], er}, 32'd3);
        run(0, 0, 3'b010, 32'h8000_0000, 0);
        chk("none_out", {lat[30:0], er}, 32'd2);
        bus.bresp = 2'b10;
        run(0, 1, 3'b010, 32'h8000_0000, 32'h1);
        bus.bresp = 2'b00;
        chk("bresp_err", {31'b0, er}, 32'd1);
        bus.rresp = 2'b11;
        run(1, 0, 3'b010, 32'h8000_0000, 0);
        bus.rresp = 2'b00;
        chk("rresp_err", {31'b0, er}, 32'd1);
        chk("rresp_data", rd, 32'd0);
        bus.rvalid = 1'b0;
        bus.in_valid = 1'b1; bus.in_ren = 1'b1; bus.in_wen = 1'b0; bus.in_rfunc = 3'b010; bus.in_raddr = 32'h8000_0000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("pre_rst_rready", {31'b0, bus.rready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_drop", {27'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
        tick();
        rst = 1'b0;
        bus.rvalid = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_out", {31'b0, bus.out_valid}, 32'd0);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
